// File: rtl/tmds_channel_bank.sv
// tmds_channel_bank: two-stage TMDS encoder for NUM_CHANNELS HDMI lanes sharing one period mode.
// Optional period-sequence checker enabled by defining TMDS_SEQ_CHECK_EN.
module tmds_channel_bank #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned DISP_W       = 5
) (
  input  logic                         clk_pixel,
  input  logic                         reset,
  input  logic [8*NUM_CHANNELS-1:0]    video_data,
  input  logic [4*NUM_CHANNELS-1:0]    data_island_data,
  input  logic [2*NUM_CHANNELS-1:0]    control_data,
  input  logic [2:0]                   mode,
  output logic [10*NUM_CHANNELS-1:0]   tmds,
  output logic                         seq_error,
  output logic [2:0]                   seq_code
);

  localparam logic [2:0] MODE_CTRL   = 3'd0;
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_VGB    = 3'd2;
  localparam logic [2:0] MODE_ISLAND = 3'd3;
  localparam logic [2:0] MODE_IGB    = 3'd4;

  localparam logic [9:0] GB_A    = 10'b1011001100;
  localparam logic [9:0] GB_B    = 10'b0100110011;
  localparam logic [9:0] CTRL_00 = 10'b1101010100;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    unique case (c)
      2'b00:   ctrl_code = 10'b1101010100;
      2'b01:   ctrl_code = 10'b0010101011;
      2'b10:   ctrl_code = 10'b0101010100;
      default: ctrl_code = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    unique case (d)
      4'h0:    terc4 = 10'b1010011100;
      4'h1:    terc4 = 10'b1001100011;
      4'h2:    terc4 = 10'b1011100100;
      4'h3:    terc4 = 10'b1011100010;
      4'h4:    terc4 = 10'b0101110001;
      4'h5:    terc4 = 10'b0100011110;
      4'h6:    terc4 = 10'b0110001110;
      4'h7:    terc4 = 10'b0100111100;
      4'h8:    terc4 = 10'b1011001100;
      4'h9:    terc4 = 10'b0100111001;
      4'hA:    terc4 = 10'b0110011100;
      4'hB:    terc4 = 10'b1011000110;
      4'hC:    terc4 = 10'b1010001110;
      4'hD:    terc4 = 10'b1001110001;
      4'hE:    terc4 = 10'b0101100011;
      default: terc4 = 10'b1011000011;
    endcase
  endfunction

  logic [2:0] s1_mode;

  // Stage-1 copy of the shared period mode
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) s1_mode <= MODE_CTRL;
    else       s1_mode <= mode;
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    localparam int unsigned HDMI_CH = c % 3;

    logic [7:0]        d;
    logic [3:0]        n1_d;
    logic [3:0]        n1_q;
    logic              use_xnor;
    logic              bit_v;
    logic [8:0]        qm_c;
    logic [8:0]        s1_qm;
    logic [3:0]        s1_n1;
    logic [1:0]        s1_ctl;
    logic [3:0]        s1_terc;
    logic [DISP_W-1:0] acc;
    logic [DISP_W-1:0] acc_n;
    logic [DISP_W-1:0] bal;
    logic [9:0]        sym_c;
    logic [9:0]        tmds_q;

    assign d = video_data[8*c +: 8];

    // Transition-minimising first stage: choose XOR/XNOR chain from input popcount
    always_comb begin
      n1_d = '0;
      for (int i = 0; i < 8; i++) n1_d = n1_d + 4'(d[i]);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
      qm_c     = '0;
      bit_v    = d[0];
      qm_c[0]  = bit_v;
      for (int i = 1; i < 8; i++) begin
        bit_v   = use_xnor ? ~(bit_v ^ d[i]) : (bit_v ^ d[i]);
        qm_c[i] = bit_v;
      end
      qm_c[8] = ~use_xnor;
      n1_q = '0;
      for (int i = 0; i < 8; i++) n1_q = n1_q + 4'(qm_c[i]);
    end

    // Stage-1 registers for this lane
    always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
        s1_qm   <= '0;
        s1_n1   <= '0;
        s1_ctl  <= '0;
        s1_terc <= '0;
      end else begin
        s1_qm   <= qm_c;
        s1_n1   <= n1_q;
        s1_ctl  <= control_data[2*c +: 2];
        s1_terc <= data_island_data[4*c +: 4];
      end
    end

    // Stage-2 symbol selection and DC-balance update; bal is N1-N0 (two's complement)
    always_comb begin
      sym_c = tmds_q;
      acc_n = '0;
      bal   = DISP_W'({s1_n1, 1'b0}) - DISP_W'(8);
      case (s1_mode)
        MODE_CTRL: sym_c = ctrl_code(s1_ctl);
        MODE_VIDEO: begin
          if ((acc == '0) || (s1_n1 == 4'd4)) begin
            sym_c = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
            acc_n = s1_qm[8] ? (acc + bal) : (acc - bal);
          end else if ((!acc[DISP_W-1] && (s1_n1 > 4'd4)) ||
                       (acc[DISP_W-1] && (s1_n1 < 4'd4))) begin
            sym_c = {1'b1, s1_qm[8], ~s1_qm[7:0]};
            acc_n = acc - bal + (s1_qm[8] ? DISP_W'(2) : DISP_W'(0));
          end else begin
            sym_c = {1'b0, s1_qm[8], s1_qm[7:0]};
            acc_n = acc + bal - (s1_qm[8] ? DISP_W'(0) : DISP_W'(2));
          end
        end
        MODE_VGB:    sym_c = (HDMI_CH == 1) ? GB_B : GB_A;
        MODE_ISLAND: sym_c = terc4(s1_terc);
        MODE_IGB:    sym_c = (HDMI_CH == 0) ? terc4({2'b11, s1_ctl}) : GB_B;
        default:     sym_c = tmds_q;
      endcase
    end

    // Stage-2 registers: output symbol and running disparity
    always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
        tmds_q <= CTRL_00;
        acc    <= '0;
      end else begin
        tmds_q <= sym_c;
        acc    <= acc_n;
      end
    end

    assign tmds[10*c +: 10] = tmds_q;
  end

`ifdef TMDS_SEQ_CHECK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_VGB, S_VIDEO, S_ILEAD, S_ISLAND, S_ITRAIL, S_HUNT
  } seq_state_t;

  seq_state_t state, state_n;
  logic [4:0] cnt, cnt_n;
  logic       err_c;
  logic [2:0] code_c;

  // Checker state, counter and registered violation report
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      seq_error <= 1'b0;
      seq_code  <= 3'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      seq_error <= err_c;
      seq_code  <= code_c;
    end
  end

  // Period-sequence rules on the raw mode input; any violation parks in HUNT until control
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_c   = 1'b0;
    code_c  = seq_code;
    case (state)
      S_IDLE: begin
        if (mode == MODE_VGB)      begin state_n = S_VGB;   cnt_n = 5'd1; end
        else if (mode == MODE_IGB) begin state_n = S_ILEAD; cnt_n = 5'd1; end
        else if (mode != MODE_CTRL) begin err_c = 1'b1; code_c = 3'd7; end
      end
      S_VGB: begin
        if ((mode == MODE_VGB) && (cnt == 5'd1))        cnt_n = 5'd2;
        else if ((mode == MODE_VIDEO) && (cnt == 5'd2)) state_n = S_VIDEO;
        else begin err_c = 1'b1; code_c = 3'd1; end
      end
      S_VIDEO: begin
        if (mode == MODE_CTRL)       state_n = S_IDLE;
        else if (mode != MODE_VIDEO) begin err_c = 1'b1; code_c = 3'd2; end
      end
      S_ILEAD: begin
        if ((mode == MODE_IGB) && (cnt == 5'd1))             cnt_n = 5'd2;
        else if ((mode == MODE_ISLAND) && (cnt == 5'd2)) begin state_n = S_ISLAND; cnt_n = 5'd1; end
        else begin err_c = 1'b1; code_c = 3'd3; end
      end
      S_ISLAND: begin
        if (mode == MODE_ISLAND)                         cnt_n = cnt + 5'd1;
        else if ((mode == MODE_IGB) && (cnt == 5'd0)) begin state_n = S_ITRAIL; cnt_n = 5'd1; end
        else begin err_c = 1'b1; code_c = 3'd4; end
      end
      S_ITRAIL: begin
        if ((mode == MODE_IGB) && (cnt == 5'd1))        cnt_n = 5'd2;
        else if ((mode == MODE_CTRL) && (cnt == 5'd2)) state_n = S_IDLE;
        else begin err_c = 1'b1; code_c = 3'd5; end
      end
      S_HUNT: begin
        if (mode == MODE_CTRL) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if ((mode > MODE_IGB) && (state != S_HUNT)) begin
      err_c  = 1'b1;
      code_c = 3'd6;
    end
    if (err_c) state_n = S_HUNT;
  end
`else
  assign seq_error = 1'b0;
  assign seq_code  = 3'd0;
`endif

endmodule

// File: tb/tb_tmds_channel_bank.sv
// Directed bench for tmds_channel_bank with six lanes; checker expectations follow TMDS_SEQ_CHECK_EN.
module tb_tmds_channel_bank;

  localparam int unsigned NCH = 6;
  localparam int unsigned DW  = 5;

`ifdef TMDS_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [2:0] M_C = 3'd0, M_V = 3'd1, M_G = 3'd2, M_I = 3'd3, M_IG = 3'd4, M_R = 3'd6;
  localparam logic [9:0] CTRL00 = 10'b1101010100;
  localparam logic [9:0] CTRL01 = 10'b0010101011;
  localparam logic [9:0] CTRL11 = 10'b1010101011;
  localparam logic [9:0] GB_A   = 10'b1011001100;
  localparam logic [9:0] GB_B   = 10'b0100110011;
  localparam logic [9:0] IGB0_01 = 10'b1001110001;

  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  // lane0: 0x00 stream, lane1: 0xFF stream, lane2: 0x0F stream (hand-computed)
  localparam logic [9:0] EXP0 [4] = '{10'b0100000000, 10'b1111111111, 10'b0100000000, 10'b1111111111};
  localparam logic [9:0] EXP1 [4] = '{10'b1000000000, 10'b0011111111, 10'b0011111111, 10'b1000000000};
  localparam logic [9:0] EXP2 [4] = '{10'b0100000101, 10'b1111111010, 10'b0100000101, 10'b1111111010};

  logic                clk_pixel = 1'b0;
  logic                reset = 1'b0;
  logic [8*NCH-1:0]    video_data = '0;
  logic [4*NCH-1:0]    data_island_data = '0;
  logic [2*NCH-1:0]    control_data = '0;
  logic [2:0]          mode = 3'd0;
  logic [10*NCH-1:0]   tmds;
  logic                seq_error;
  logic [2:0]          seq_code;

  int errors = 0;
  int checks = 0;

  always #5 clk_pixel = ~clk_pixel;

  tmds_channel_bank #(.NUM_CHANNELS(NCH), .DISP_W(DW)) dut (
    .clk_pixel        (clk_pixel),
    .reset            (reset),
    .video_data       (video_data),
    .data_island_data (data_island_data),
    .control_data     (control_data),
    .mode             (mode),
    .tmds             (tmds),
    .seq_error        (seq_error),
    .seq_code         (seq_code)
  );

  function automatic logic [9:0] lane(input int c);
    return tmds[10*c +: 10];
  endfunction

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  // Lanes 3..5 mirror lanes 0..2
  task automatic drive(input logic [2:0] m, input logic [7:0] v0, input logic [7:0] v1,
                       input logic [7:0] v2, input logic [3:0] isl, input logic [1:0] ctl);
    mode             = m;
    video_data       = {v2, v1, v0, v2, v1, v0};
    data_island_data = {NCH{isl}};
    control_data     = {NCH{ctl}};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(M_C, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00);
    repeat (2) @(posedge clk_pixel);
    @(negedge clk_pixel);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(M_C, 8'h00, 8'h00, 8'h00, 4'h0, 2'b11);
    #3;
    checks++;
    if (tmds !== {NCH{CTRL00}}) begin errors++; $display("FAIL reset_async tmds got %h exp %h", tmds, {NCH{CTRL00}}); end
    checks++;
    if (seq_error !== 1'b0 || seq_code !== 3'd0) begin errors++; $display("FAIL reset_seq got err=%b code=%0d exp 0/0", seq_error, seq_code); end
    tick(); tick();
    checks++;
    if (tmds !== {NCH{CTRL00}}) begin errors++; $display("FAIL reset_held tmds got %h exp %h", tmds, {NCH{CTRL00}}); end
    @(negedge clk_pixel);
    reset = 1'b0;
    tick();
    checks++;
    if (tmds !== {NCH{CTRL00}}) begin errors++; $display("FAIL reset_rel1 tmds got %h exp %h", tmds, {NCH{CTRL00}}); end
    tick();
    checks++;
    if (tmds !== {NCH{CTRL11}}) begin errors++; $display("FAIL reset_rel2 tmds got %h exp %h", tmds, {NCH{CTRL11}}); end
  endtask

  task automatic test_video();
    logic [9:0] e;
    do_reset();
    drive(M_G, 8'h00, 8'hFF, 8'h0F, 4'h0, 2'b00); tick();
    drive(M_G, 8'h00, 8'hFF, 8'h0F, 4'h0, 2'b00); tick();
    for (int c = 0; c < NCH; c++) begin
      e = (c % 3 == 1) ? GB_B : GB_A;
      checks++;
      if (lane(c) !== e) begin errors++; $display("FAIL vgb1 lane%0d got %b exp %b", c, lane(c), e); end
    end
    drive(M_V, 8'h00, 8'hFF, 8'h0F, 4'h0, 2'b00); tick();
    for (int c = 0; c < NCH; c++) begin
      e = (c % 3 == 1) ? GB_B : GB_A;
      checks++;
      if (lane(c) !== e) begin errors++; $display("FAIL vgb2 lane%0d got %b exp %b", c, lane(c), e); end
    end
    for (int k = 0; k < 4; k++) begin
      drive((k < 3) ? M_V : M_C, 8'h00, 8'hFF, 8'h0F, 4'h0, 2'b00); tick();
      for (int c = 0; c < 3; c++) begin
        e = (c == 0) ? EXP0[k] : ((c == 1) ? EXP1[k] : EXP2[k]);
        checks++;
        if (lane(c) !== e) begin errors++; $display("FAIL video sym%0d lane%0d got %b exp %b", k, c, lane(c), e); end
      end
      checks++;
      if (seq_error !== 1'b0) begin errors++; $display("FAIL video_seq_err sym%0d got %b exp 0", k, seq_error); end
    end
    drive(M_C, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (lane(0) !== CTRL00) begin errors++; $display("FAIL video_exit lane0 got %b exp %b", lane(0), CTRL00); end
  endtask

  task automatic test_island();
    logic [9:0] e;
    do_reset();
    drive(M_IG, 8'h00, 8'h00, 8'h00, 4'h0, 2'b01); tick();
    drive(M_IG, 8'h00, 8'h00, 8'h00, 4'h0, 2'b01); tick();
    for (int c = 0; c < NCH; c++) begin
      e = (c % 3 == 0) ? IGB0_01 : GB_B;
      checks++;
      if (lane(c) !== e) begin errors++; $display("FAIL igb_lead lane%0d got %b exp %b", c, lane(c), e); end
    end
    drive(M_I, 8'h00, 8'h00, 8'h00, 4'h0, 2'b01); tick();
    checks++;
    if (lane(0) !== IGB0_01 || lane(1) !== GB_B) begin
      errors++; $display("FAIL igb_lead2 lane0 %b lane1 %b exp %b %b", lane(0), lane(1), IGB0_01, GB_B);
    end
    for (int i = 1; i < 32; i++) begin
      drive(M_I, 8'h00, 8'h00, 8'h00, 4'(i), 2'b01); tick();
      checks++;
      if (lane(0) !== TERC[(i-1) % 16] || lane(1) !== TERC[(i-1) % 16]) begin
        errors++; $display("FAIL terc4 idx%0d lane0 %b lane1 %b exp %b", i-1, lane(0), lane(1), TERC[(i-1) % 16]);
      end
      checks++;
      if (seq_error !== 1'b0) begin errors++; $display("FAIL island_seq_err idx%0d got %b exp 0", i, seq_error); end
    end
    drive(M_IG, 8'h00, 8'h00, 8'h00, 4'h0, 2'b01); tick();
    checks++;
    if (lane(0) !== TERC[15]) begin errors++; $display("FAIL terc4_last lane0 got %b exp %b", lane(0), TERC[15]); end
    drive(M_IG, 8'h00, 8'h00, 8'h00, 4'h0, 2'b01); tick();
    checks++;
    if (lane(0) !== IGB0_01 || lane(2) !== GB_B) begin
      errors++; $display("FAIL igb_trail lane0 %b lane2 %b exp %b %b", lane(0), lane(2), IGB0_01, GB_B);
    end
    drive(M_C, 8'h00, 8'h00, 8'h00, 4'h0, 2'b01); tick();
    drive(M_C, 8'h00, 8'h00, 8'h00, 4'h0, 2'b01); tick();
    checks++;
    if (lane(0) !== CTRL01) begin errors++; $display("FAIL ctrl01 lane0 got %b exp %b", lane(0), CTRL01); end
    checks++;
    if (seq_error !== 1'b0 || seq_code !== 3'd0) begin
      errors++; $display("FAIL island_legal got err=%b code=%0d exp 0/0", seq_error, seq_code);
    end
  endtask

  task automatic test_seq_errors();
    do_reset();
    drive(M_C, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_G, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_V, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (seq_error !== CHK || seq_code !== (CHK ? 3'd1 : 3'd0)) begin
      errors++; $display("FAIL vgb_short got err=%b code=%0d exp %b/%0d", seq_error, seq_code, CHK, CHK ? 1 : 0);
    end
    drive(M_C, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (seq_error !== 1'b0 || seq_code !== (CHK ? 3'd1 : 3'd0)) begin
      errors++; $display("FAIL err_pulse_hold got err=%b code=%0d exp 0/%0d", seq_error, seq_code, CHK ? 1 : 0);
    end
    drive(M_V, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (seq_error !== CHK || seq_code !== (CHK ? 3'd7 : 3'd0)) begin
      errors++; $display("FAIL idle_illegal got err=%b code=%0d exp %b/%0d", seq_error, seq_code, CHK, CHK ? 7 : 0);
    end
    do_reset();
    checks++;
    if (seq_code !== 3'd0) begin errors++; $display("FAIL code_reset got %0d exp 0", seq_code); end
    drive(M_IG, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_IG, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    for (int i = 0; i < 31; i++) begin
      drive(M_I, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    end
    checks++;
    if (seq_error !== 1'b0) begin errors++; $display("FAIL island31_pre got %b exp 0", seq_error); end
    drive(M_IG, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (seq_error !== CHK || seq_code !== (CHK ? 3'd4 : 3'd0)) begin
      errors++; $display("FAIL island31 got err=%b code=%0d exp %b/%0d", seq_error, seq_code, CHK, CHK ? 4 : 0);
    end
    drive(M_C, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_IG, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_I, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (seq_error !== CHK || seq_code !== (CHK ? 3'd3 : 3'd0)) begin
      errors++; $display("FAIL ilead_short got err=%b code=%0d exp %b/%0d", seq_error, seq_code, CHK, CHK ? 3 : 0);
    end
  endtask

  task automatic test_reserved();
    do_reset();
    drive(M_G, 8'hFF, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_G, 8'hFF, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_V, 8'hFF, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_V, 8'hFF, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (lane(0) !== 10'b1000000000) begin errors++; $display("FAIL rsv_v1 lane0 got %b exp %b", lane(0), 10'b1000000000); end
    drive(M_R, 8'hFF, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (lane(0) !== 10'b0011111111) begin errors++; $display("FAIL rsv_v2 lane0 got %b exp %b", lane(0), 10'b0011111111); end
    checks++;
    if (seq_error !== CHK || seq_code !== (CHK ? 3'd6 : 3'd0)) begin
      errors++; $display("FAIL rsv_code got err=%b code=%0d exp %b/%0d", seq_error, seq_code, CHK, CHK ? 6 : 0);
    end
    drive(M_V, 8'hFF, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (lane(0) !== 10'b0011111111) begin errors++; $display("FAIL rsv_hold lane0 got %b exp %b", lane(0), 10'b0011111111); end
    checks++;
    if (seq_error !== 1'b0 || seq_code !== (CHK ? 3'd6 : 3'd0)) begin
      errors++; $display("FAIL hunt_quiet got err=%b code=%0d exp 0/%0d", seq_error, seq_code, CHK ? 6 : 0);
    end
    drive(M_C, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    checks++;
    if (lane(0) !== 10'b1000000000) begin errors++; $display("FAIL rsv_acc_clr lane0 got %b exp %b", lane(0), 10'b1000000000); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(M_G, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_G, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_V, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    drive(M_R, 8'h00, 8'h00, 8'h00, 4'h0, 2'b00); tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (tmds !== {NCH{CTRL00}}) begin errors++; $display("FAIL mid_reset tmds got %h exp %h", tmds, {NCH{CTRL00}}); end
    checks++;
    if (seq_error !== 1'b0 || seq_code !== 3'd0) begin
      errors++; $display("FAIL mid_reset_seq got err=%b code=%0d exp 0/0", seq_error, seq_code);
    end
    drive(M_V, 8'hFF, 8'hFF, 8'hFF, 4'h0, 2'b00);
    @(negedge clk_pixel);
    reset = 1'b0;
    tick();
    checks++;
    if (tmds !== {NCH{CTRL00}}) begin errors++; $display("FAIL post_reset_ctrl tmds got %h exp %h", tmds, {NCH{CTRL00}}); end
  endtask

  initial begin
    test_reset();
    test_video();
    test_island();
    test_seq_errors();
    test_reserved();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
